// File: rtl/encoder_align_seq_if.sv
// Purpose : groups the control, decoder-strobe and status signals of the encoder alignment sequencer.
// Latency : n/a (wires only).
// Backpressure: none; all inputs are single-cycle strobes and all outputs are levels or one-cycle pulses.
//
// master: PS control registers / decoder side (drives strobes, reads status)
// slave : encoder_align_seq (reads strobes, drives status)
//   start, abort, fault_clr : single-cycle control requests
//   step_pulse, illegal     : decoder strobes
//   align_en                : hold alignment vector (to PWM block)
//   zero_req                : one-cycle zero command (to decoder)
//   pos_valid, busy, fault  : status levels
//   fault_code[1:0]         : 0 none, 1 settle timeout, 2 illegal limit
//   state[2:0]              : debug view of the sequencer state
interface encoder_align_seq_if;
    logic       start;
    logic       abort;
    logic       fault_clr;
    logic       step_pulse;
    logic       illegal;
    logic       align_en;
    logic       zero_req;
    logic       pos_valid;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    modport master (
        output start, abort, fault_clr, step_pulse, illegal,
        input  align_en, zero_req, pos_valid, busy, fault, fault_code, state
    );

    modport slave (
        input  start, abort, fault_clr, step_pulse, illegal,
        output align_en, zero_req, pos_valid, busy, fault, fault_code, state
    );
endinterface

// File: rtl/encoder_align_seq.sv
// Purpose : aligns the rotor to electrical zero, references the quadrature decoder, then supervises decoder health.
// Latency : all outputs registered; a request seen on cycle N is reflected on the outputs in cycle N+1.
// Backpressure: none; strobes are sampled every cycle and never stalled.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, forces IDLE and all outputs low immediately
//   bus  : encoder_align_seq_if.slave (control strobes in, align/zero/status out)
module encoder_align_seq #(
    parameter int unsigned ALIGN_CYCLES   = 1000000,
    parameter int unsigned SETTLE_CYCLES  = 100000,
    parameter int unsigned SETTLE_TIMEOUT = 5000000,
    parameter int unsigned ILLEGAL_LIMIT  = 4,
    parameter int unsigned ILLEGAL_WINDOW = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    encoder_align_seq_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_SETTLE = 3'd2,
        S_ZERO   = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_ILLEGAL = 2'd2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_fault_code_nxt;

    // r_timer: cycles spent in the current state (ALIGN / SETTLE)
    // r_quiet: consecutive step-free SETTLE cycles before the current one
    // r_win  : position inside the illegal-count window during RUN
    // r_ill  : illegal strobes seen in the current window
    logic [31:0] r_timer;
    logic [31:0] r_quiet;
    logic [31:0] r_win;
    logic [31:0] r_ill;

    logic        r_align_en;
    logic        r_zero_req;
    logic        r_pos_valid;
    logic        r_busy;
    logic        r_fault;

    logic        w_align_done;
    logic        w_settle_done;
    logic        w_settle_to;
    logic        w_win_wrap;
    logic [31:0] w_ill_nxt;
    logic        w_ill_hit;

    assign w_align_done  = (r_timer == 32'(ALIGN_CYCLES - 1));
    // The current cycle must itself be quiet to complete the settle run.
    assign w_settle_done = (r_quiet == 32'(SETTLE_CYCLES - 1)) && !bus.step_pulse;
    assign w_settle_to   = (r_timer == 32'(SETTLE_TIMEOUT - 1));
    assign w_win_wrap    = (r_win == 32'(ILLEGAL_WINDOW - 1));

    // A strobe on the wrap cycle opens the new window with a count of one.
    assign w_ill_nxt = w_win_wrap ? {31'd0, bus.illegal}
                                  : r_ill + {31'd0, bus.illegal};
    assign w_ill_hit = bus.illegal && (w_ill_nxt >= 32'(ILLEGAL_LIMIT));

    // Next-state: abort > fault detection > start > normal progression.
    always_comb begin
        w_state_nxt      = r_state;
        w_fault_code_nxt = r_fault_code;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_state_nxt = S_ALIGN;
            end
            S_ALIGN: begin
                if (bus.abort)        w_state_nxt = S_IDLE;
                else if (w_align_done) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_settle_done) begin
                    // A settled rotor wins over a timeout landing on the same cycle.
                    w_state_nxt = S_ZERO;
                end else if (w_settle_to) begin
                    w_state_nxt      = S_FAULT;
                    w_fault_code_nxt = FC_TIMEOUT;
                end
            end
            S_ZERO: begin
                if (bus.abort) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_ill_hit) begin
                    w_state_nxt      = S_FAULT;
                    w_fault_code_nxt = FC_ILLEGAL;
                end else if (bus.start) begin
                    w_state_nxt = S_ALIGN;
                end
            end
            S_FAULT: begin
                if (bus.fault_clr) begin
                    w_state_nxt      = S_IDLE;
                    w_fault_code_nxt = FC_NONE;
                end
            end
            default: begin
                w_state_nxt      = S_IDLE;
                w_fault_code_nxt = FC_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fault_code <= FC_NONE;
            r_timer      <= '0;
            r_quiet      <= '0;
            r_win        <= '0;
            r_ill        <= '0;
            r_align_en   <= 1'b0;
            r_zero_req   <= 1'b0;
            r_pos_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fault_code <= w_fault_code_nxt;

            // Outputs are decoded from the next state so they change with the state register.
            r_align_en  <= (w_state_nxt == S_ALIGN) || (w_state_nxt == S_SETTLE) ||
                           (w_state_nxt == S_ZERO);
            r_busy      <= (w_state_nxt == S_ALIGN) || (w_state_nxt == S_SETTLE) ||
                           (w_state_nxt == S_ZERO);
            r_zero_req  <= (w_state_nxt == S_ZERO);
            r_pos_valid <= (w_state_nxt == S_RUN);
            r_fault     <= (w_state_nxt == S_FAULT);

            // Every state entry starts all counters from zero.
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
                r_quiet <= '0;
                r_win   <= '0;
                r_ill   <= '0;
            end else begin
                case (r_state)
                    S_ALIGN: begin
                        r_timer <= r_timer + 32'd1;
                    end
                    S_SETTLE: begin
                        r_timer <= r_timer + 32'd1;
                        r_quiet <= bus.step_pulse ? 32'd0 : r_quiet + 32'd1;
                    end
                    S_RUN: begin
                        r_win <= w_win_wrap ? 32'd0 : r_win + 32'd1;
                        r_ill <= w_ill_nxt;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.align_en   = r_align_en;
    assign bus.zero_req   = r_zero_req;
    assign bus.pos_valid  = r_pos_valid;
    assign bus.busy       = r_busy;
    assign bus.fault      = r_fault;
    assign bus.fault_code = r_fault_code;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_encoder_align_seq.sv
// Purpose : directed-vector bench for encoder_align_seq with hand-computed expected outputs.
// Latency : checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_encoder_align_seq;

    localparam int ALIGN_C   = 10;
    localparam int SETTLE_C  = 5;
    localparam int TIMEOUT_C = 20;
    localparam int ILL_LIM   = 3;
    localparam int ILL_WIN   = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ZERO   = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    encoder_align_seq_if bus_if ();

    encoder_align_seq #(
        .ALIGN_CYCLES   (ALIGN_C),
        .SETTLE_CYCLES  (SETTLE_C),
        .SETTLE_TIMEOUT (TIMEOUT_C),
        .ILLEGAL_LIMIT  (ILL_LIM),
        .ILLEGAL_WINDOW (ILL_WIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {state, align_en, zero_req, pos_valid, busy, fault, fault_code}
    function automatic logic [9:0] outs();
        return {bus_if.state, bus_if.align_en, bus_if.zero_req, bus_if.pos_valid,
                bus_if.busy, bus_if.fault, bus_if.fault_code};
    endfunction

    // Output table per state, as listed in the behaviour description.
    function automatic logic [9:0] exp_outs(input logic [2:0] st, input logic [1:0] code);
        logic forcing;
        forcing = (st == ST_ALIGN) || (st == ST_SETTLE) || (st == ST_ZERO);
        return {st, forcing, st == ST_ZERO, st == ST_RUN, forcing, st == ST_FAULT, code};
    endfunction

    task automatic st_chk(input string tag, input logic [2:0] st, input logic [1:0] code);
        chk(tag, {22'd0, outs()}, {22'd0, exp_outs(st, code)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
    endtask

    task automatic pulse_clr();
        bus_if.fault_clr = 1'b1;
        tick();
        bus_if.fault_clr = 1'b0;
    endtask

    // start -> 10 ALIGN + 5 SETTLE + 1 ZERO -> first RUN cycle
    task automatic goto_run();
        pulse_start();
        repeat (16) tick();
        st_chk("goto_run", ST_RUN, 2'd0);
    endtask

    initial begin
        int zc;
        rst               = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.abort      = 1'b0;
        bus_if.fault_clr  = 1'b0;
        bus_if.step_pulse = 1'b0;
        bus_if.illegal    = 1'b0;

        repeat (2) tick();
        chk("reset_outs", {22'd0, outs()}, 32'd0);
        rst = 1'b0;
        tick();
        st_chk("idle_after_rst", ST_IDLE, 2'd0);

        // Nominal: align_en cycles 1..16, zero_req at 16, pos_valid from 17.
        pulse_start();
        for (int c = 1; c <= 16; c++) begin
            st_chk("nominal", (c <= 10) ? ST_ALIGN : ((c <= 15) ? ST_SETTLE : ST_ZERO), 2'd0);
            tick();
        end
        st_chk("nominal_run", ST_RUN, 2'd0);

        // Illegal limit: strobes at window cycles 2, 5, 9 -> FAULT code 2 next cycle.
        for (int w = 0; w < 10; w++) begin
            st_chk("ill_run", ST_RUN, 2'd0);
            bus_if.illegal = (w == 2 || w == 5 || w == 9);
            tick();
        end
        bus_if.illegal = 1'b0;
        st_chk("ill_fault", ST_FAULT, 2'd2);
        pulse_start();
        st_chk("fault_start_ign", ST_FAULT, 2'd2);
        pulse_abort();
        st_chk("fault_abort_ign", ST_FAULT, 2'd2);
        pulse_clr();
        st_chk("fault_clr", ST_IDLE, 2'd0);

        // Window wrap: strobes 2, 5, 18 straddle the wrap at 15 -> no fault.
        goto_run();
        for (int w = 0; w < 25; w++) begin
            st_chk("wrap_run", ST_RUN, 2'd0);
            bus_if.illegal = (w == 2 || w == 5 || w == 18);
            tick();
        end
        bus_if.illegal = 1'b0;
        st_chk("wrap_nofault", ST_RUN, 2'd0);
        pulse_abort();
        st_chk("run_abort", ST_IDLE, 2'd0);

        // Strobe on the wrap cycle counts as 1 in the new window: 15, 18, 20 -> fault.
        goto_run();
        for (int w = 0; w <= 20; w++) begin
            st_chk("wrapcnt_run", ST_RUN, 2'd0);
            bus_if.illegal = (w == 15 || w == 18 || w == 20);
            tick();
        end
        bus_if.illegal = 1'b0;
        st_chk("wrapcnt_fault", ST_FAULT, 2'd2);
        pulse_clr();
        st_chk("wrapcnt_clr", ST_IDLE, 2'd0);

        // Settle restart: steps at SETTLE cycles 3, 7, 12 -> ZERO at SETTLE cycle 18.
        pulse_start();
        repeat (10) tick();
        for (int s = 0; s < 18; s++) begin
            st_chk("settle_rst", ST_SETTLE, 2'd0);
            bus_if.step_pulse = (s == 3 || s == 7 || s == 12);
            tick();
        end
        bus_if.step_pulse = 1'b0;
        st_chk("settle_zero", ST_ZERO, 2'd0);
        tick();
        st_chk("settle_run", ST_RUN, 2'd0);

        // start in RUN restarts the whole sequence with one more zero_req.
        pulse_start();
        st_chk("rerun_align", ST_ALIGN, 2'd0);
        zc = 0;
        for (int i = 0; i < 16; i++) begin
            zc += int'(bus_if.zero_req);
            tick();
        end
        chk("rerun_zreq_cnt", zc, 32'd1);
        st_chk("rerun_run", ST_RUN, 2'd0);
        pulse_abort();

        // Timeout: step every 3 cycles keeps quiet short -> FAULT after 20 SETTLE cycles.
        pulse_start();
        repeat (10) tick();
        for (int s = 0; s < 20; s++) begin
            st_chk("to_settle", ST_SETTLE, 2'd0);
            bus_if.step_pulse = ((s % 3) == 2);
            tick();
        end
        bus_if.step_pulse = 1'b0;
        st_chk("timeout_fault", ST_FAULT, 2'd1);
        pulse_start();
        st_chk("to_start_ign", ST_FAULT, 2'd1);
        pulse_clr();
        st_chk("to_clr", ST_IDLE, 2'd0);

        // Settle completes on the same cycle the timeout hits -> ZERO wins.
        pulse_start();
        repeat (10) tick();
        for (int s = 0; s < 20; s++) begin
            st_chk("tie_settle", ST_SETTLE, 2'd0);
            bus_if.step_pulse = ((s % 3) == 2) && (s <= 14);
            tick();
        end
        bus_if.step_pulse = 1'b0;
        st_chk("tie_zero", ST_ZERO, 2'd0);
        tick();
        pulse_abort();
        st_chk("tie_abort", ST_IDLE, 2'd0);

        // Abort mid-ALIGN; abort and fault_clr in IDLE do nothing.
        pulse_start();
        repeat (3) tick();
        st_chk("abort_align_pre", ST_ALIGN, 2'd0);
        pulse_abort();
        st_chk("abort_align", ST_IDLE, 2'd0);
        pulse_abort();
        st_chk("abort_idle", ST_IDLE, 2'd0);
        pulse_clr();
        st_chk("clr_idle", ST_IDLE, 2'd0);

        // Abort and start together in SETTLE -> IDLE.
        pulse_start();
        repeat (10) tick();
        st_chk("both_pre", ST_SETTLE, 2'd0);
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        tick();
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        st_chk("both_idle", ST_IDLE, 2'd0);

        // Async reset mid-RUN: outputs clear with no clock edge.
        goto_run();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {22'd0, outs()}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        st_chk("post_rst", ST_IDLE, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/encoder_align_seq.md
Name: encoder_align_seq

Overview:
- Sequencer for the 12-bit quadrature position decoder in the ESC.
- On start, it holds the rotor at electrical zero, waits for the encoder to stop moving, then pulses the decoder's zero request.
- It then declares position valid and supervises decoder health. Repeated illegal transitions raise a latched fault.
- Sits between the PS control registers, the commutation/PWM block (align_en) and the decoder (zero_req, step_pulse, illegal).

Parameters:
- ALIGN_CYCLES, 1000000: cycles align_en is held before settle checking (10 ms at 100 MHz); must be >= 1.
- SETTLE_CYCLES, 100000: consecutive cycles with no step_pulse required to declare the rotor settled; must be >= 1.
- SETTLE_TIMEOUT, 5000000: maximum cycles allowed in SETTLE before a fault; must be > SETTLE_CYCLES.
- ILLEGAL_LIMIT, 4: illegal pulses within one window that trigger a fault; range 1..255.
- ILLEGAL_WINDOW, 65536: length in cycles of the illegal-count window during RUN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high; clock clk
- start  in  1  single-cycle request to begin or restart alignment
- abort  in  1  single-cycle request to stop and return to IDLE
- fault_clr  in  1  single-cycle request to clear a latched fault
- step_pulse  in  1  accepted-step strobe from the decoder
- illegal  in  1  illegal-transition strobe from the decoder
- align_en  out  1  commands the PWM block to hold the alignment vector
- zero_req  out  1  one-cycle zero command to the decoder
- pos_valid  out  1  decoder position is referenced and trustworthy
- busy  out  1  high in ALIGN, SETTLE and ZERO
- fault  out  1  latched fault flag
- fault_code  out  2  0 none, 1 settle timeout, 2 illegal limit
- state  out  3  current state encoding, for debug

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- States: IDLE=0, ALIGN=1, SETTLE=2, ZERO=3, RUN=4, FAULT=5. All outputs are registered and decoded from state.
- Priority within a cycle: rst > abort > fault detection > start > normal transition.
- IDLE: start -> ALIGN. Timer cleared on every state entry.
- ALIGN: align_en=1.
  - Timer counts from 0; at timer==ALIGN_CYCLES-1 -> SETTLE.
  - ALIGN therefore lasts exactly ALIGN_CYCLES cycles.
- SETTLE: align_en=1.
  - Quiet counter resets to 0 on any step_pulse, otherwise increments.
  - Quiet counter reaching SETTLE_CYCLES-1 without a step_pulse that cycle -> ZERO.
  - Total timer reaching SETTLE_TIMEOUT-1 -> FAULT, code 1.
  - If both conditions hit in the same cycle, ZERO wins.
- ZERO: align_en=1, zero_req=1 for exactly this one cycle -> RUN.
- RUN: align_en=0, pos_valid=1 from the first RUN cycle. Decoder position reads 0 on that cycle.
  - Window counter counts 0..ILLEGAL_WINDOW-1 and wraps.
  - Illegal counter increments on illegal and clears on window wrap. If illegal coincides with the wrap, the counter becomes 1.
  - Illegal counter reaching ILLEGAL_LIMIT (including the incrementing cycle) -> FAULT, code 2.
- illegal during ALIGN/SETTLE/ZERO is ignored; the rotor is being forced and noise is expected.
- FAULT: fault=1, align_en=0, pos_valid=0, fault_code held.
  - start and abort are ignored.
  - fault_clr -> IDLE, fault and fault_code cleared on the next cycle.
- abort in ALIGN/SETTLE/ZERO/RUN -> IDLE next cycle; align_en and pos_valid drop that cycle. abort in IDLE: no effect.
- start in ALIGN/SETTLE/ZERO: ignored. start in RUN -> ALIGN, pos_valid drops next cycle, counters cleared.
- fault_clr outside FAULT: no effect.
- Counter width: 32 bits unsigned, no overflow possible within the parameter ranges.
- Asynchronous reset mid-sequence forces IDLE immediately; align_en deasserts asynchronously.

Test Plan:
- Nominal: ALIGN_CYCLES=10, SETTLE_CYCLES=5, no steps, pulse start at cycle 0 -> align_en high cycles 1..16, zero_req high at cycle 16 only, pos_valid high from cycle 17, busy low from 17.
- Settle restart: step_pulse at SETTLE cycles 3 and 7 -> ZERO entered 5 cycles after the last step; a step_pulse on the would-be final quiet cycle delays ZERO by 5 more cycles.
- Timeout: SETTLE_TIMEOUT=20, step_pulse every 3 cycles -> FAULT after 20 SETTLE cycles, fault_code=1, align_en=0; start ignored; fault_clr -> IDLE, fault=0.
- Illegal limit: ILLEGAL_LIMIT=3, ILLEGAL_WINDOW=16, in RUN pulse illegal at window cycles 2,5,9 -> FAULT code 2 on the cycle after the third pulse. A second run with pulses 2,5 then 18 crosses the wrap -> no fault.
- Abort/restart: abort mid-ALIGN -> IDLE, align_en low next cycle; start in RUN -> ALIGN, pos_valid low, full sequence repeats with a second zero_req pulse.
- Same-cycle abort and start in SETTLE -> IDLE. Async rst asserted mid-RUN -> all outputs 0 without a clock edge.
